// File: rtl/sr_latch_arbiter_pkg.sv
// Shared encodings for the SR latch arbiter: FSM states, command codes and
// the strobe counter width.
package sr_latch_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StStrobe = 3'd2,
        StHold   = 3'd3,
        StDone   = 3'd4,
        StError  = 3'd5
    } state_e;

    // Encoded as {set, clr}
    typedef enum logic [1:0] {
        CmdNop = 2'b00,
        CmdClr = 2'b01,
        CmdSet = 2'b10,
        CmdIll = 2'b11
    } cmd_e;

    localparam int unsigned CntW = 4;

endpackage

// File: rtl/sr_latch_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo NREQ.
module rr_priority_pick
    import sr_latch_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] pick,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    int j;

    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = int'(ptr) + k;
            if (j >= int'(NREQ)) begin
                j = j - int'(NREQ);
            end
            if (!valid && req[j]) begin
                valid   = 1'b1;
                pick[j] = 1'b1;
                idx     = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter sequencing one gated SR latch through a
// setup/strobe/hold cycle; every output is a flop.
module sr_latch_arbiter
    import sr_latch_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned STROBE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] set_cmd,
    input  logic [NREQ-1:0] clr_cmd,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] ack,
    output logic [NREQ-1:0] err,
    output logic            latch_s,
    output logic            latch_r,
    output logic            latch_en,
    output logic            busy,
    output logic            q_shadow
);

    localparam int unsigned IdxW = $clog2(NREQ);

    state_e          state_q;
    cmd_e            cmd_q;
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] idx_q;
    logic [NREQ-1:0] sel_q;
    logic [CntW-1:0] cnt_q;

    logic [NREQ-1:0] pick;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic            drive;

    rr_priority_pick #(
        .NREQ (NREQ),
        .IDXW (IdxW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign drive = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cmd_q    <= CmdNop;
            ptr_q    <= '0;
            idx_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            gnt      <= '0;
            ack      <= '0;
            err      <= '0;
            latch_s  <= 1'b0;
            latch_r  <= 1'b0;
            latch_en <= 1'b0;
            busy     <= 1'b0;
            q_shadow <= 1'b0;
        end else begin
            // Outputs are registered decodes of the current state, so they trail it by one cycle.
            busy     <= (state_q != StIdle);
            gnt      <= (state_q != StIdle) ? sel_q : '0;
            latch_s  <= drive && (cmd_q == CmdSet);
            latch_r  <= drive && (cmd_q == CmdClr);
            latch_en <= (state_q == StStrobe);
            ack      <= (state_q == StDone) ? sel_q : '0;
            err      <= (state_q == StError) ? sel_q : '0;
            if (state_q == StDone) begin
                if (cmd_q == CmdSet) begin
                    q_shadow <= 1'b1;
                end else if (cmd_q == CmdClr) begin
                    q_shadow <= 1'b0;
                end
            end

            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        idx_q   <= pick_idx;
                        sel_q   <= pick;
                        cmd_q   <= cmd_e'({set_cmd[pick_idx], clr_cmd[pick_idx]});
                        state_q <= (set_cmd[pick_idx] && clr_cmd[pick_idx]) ? StError : StSetup;
                    end
                end
                StSetup: begin
                    cnt_q   <= CntW'(1);
                    state_q <= StStrobe;
                end
                StStrobe: begin
                    if (cnt_q == CntW'(STROBE_CYC)) begin
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    state_q <= StDone;
                end
                StDone, StError: begin
                    ptr_q   <= (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Directed bench for sr_latch_arbiter: two instances (STROBE_CYC 1 and 3), an
// expected-completion queue, and continuous latch/grant invariant checks.
module tb_sr_latch_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_a [2];
    logic [3:0] set_a [2];
    logic [3:0] clr_a [2];
    logic [3:0] gnt_a [2];
    logic [3:0] ack_a [2];
    logic [3:0] err_a [2];
    logic       s_a [2];
    logic       r_a [2];
    logic       en_a [2];
    logic       busy_a [2];
    logic       q_a [2];

    int n_assert = 0;
    int n_fail   = 0;
    int sb[$];

    int         r_lat, r_en_cnt, r_en_first, r_s_first, r_s_cnt;
    logic [3:0] r_g1, r_done, seen;
    logic       r_is_err, r_b0, r_b1, r_bdone;
    logic       prev_en [2];
    logic       prev_s [2];
    logic       prev_r [2];

    always #5 clk = ~clk;

    sr_latch_arbiter #(.NREQ(4), .STROBE_CYC(1)) dut_a (
        .clk (clk), .rst (rst), .req (req_a[0]), .set_cmd (set_a[0]), .clr_cmd (clr_a[0]),
        .gnt (gnt_a[0]), .ack (ack_a[0]), .err (err_a[0]), .latch_s (s_a[0]),
        .latch_r (r_a[0]), .latch_en (en_a[0]), .busy (busy_a[0]), .q_shadow (q_a[0])
    );

    sr_latch_arbiter #(.NREQ(4), .STROBE_CYC(3)) dut_b (
        .clk (clk), .rst (rst), .req (req_a[1]), .set_cmd (set_a[1]), .clr_cmd (clr_a[1]),
        .gnt (gnt_a[1]), .ack (ack_a[1]), .err (err_a[1]), .latch_s (s_a[1]),
        .latch_r (r_a[1]), .latch_en (en_a[1]), .busy (busy_a[1]), .q_shadow (q_a[1])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // First tick is the edge that samples req in IDLE; c counts cycles after it.
    task automatic run(input int d, input bit churn);
        int         e;
        logic [3:0] ev;
        r_lat = -1; r_en_cnt = 0; r_en_first = -1; r_s_first = -1; r_s_cnt = 0;
        r_g1 = '0; r_done = '0; r_is_err = 1'b0; r_b1 = 1'b0; r_bdone = 1'b0;
        tick;
        r_b0 = busy_a[d];
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (c == 1) begin
                r_g1 = gnt_a[d];
                r_b1 = busy_a[d];
                if (churn) begin
                    set_a[d][0] = 1'b0;
                    clr_a[d][0] = 1'b1;
                    req_a[d][0] = 1'b0;
                end
            end
            if (en_a[d]) begin
                r_en_cnt++;
                if (r_en_first < 0) r_en_first = c;
            end
            if (s_a[d] || r_a[d]) begin
                r_s_cnt++;
                if (r_s_first < 0) r_s_first = c;
            end
            if ((ack_a[d] | err_a[d]) != 4'b0000) begin
                r_lat    = c;
                r_done   = ack_a[d] | err_a[d];
                r_is_err = |err_a[d];
                r_bdone  = busy_a[d];
                break;
            end
        end
        chk("done_within_budget", 32'(r_lat >= 0), 32'd1);
        chk("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e  = sb.pop_front();
            ev = '0;
            ev[e % 16] = 1'b1;
            chk("sb_done_vec", 32'(r_done), 32'(ev));
            chk("sb_kind_err", 32'(r_is_err), 32'(e / 16));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_en[d] = 1'b0;
            end else begin
                n_assert++;
                assert (!(s_a[d] && r_a[d]) && $onehot0(gnt_a[d])) else begin
                    n_fail++;
                    $error("FAIL inv_sr_gnt dut%0d: observed s=%b r=%b gnt=%b, required s&r=0 gnt onehot0",
                           d, s_a[d], r_a[d], gnt_a[d]);
                end
                if (prev_en[d]) begin
                    n_assert++;
                    assert (s_a[d] === prev_s[d] && r_a[d] === prev_r[d]) else begin
                        n_fail++;
                        $error("FAIL inv_sr_stable dut%0d: observed s=%b r=%b, required s=%b r=%b",
                               d, s_a[d], r_a[d], prev_s[d], prev_r[d]);
                    end
                end
                prev_en[d] = en_a[d];
                prev_s[d]  = s_a[d];
                prev_r[d]  = r_a[d];
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_a[d] = '0; set_a[d] = '0; clr_a[d] = '0;
            prev_en[d] = 1'b0; prev_s[d] = 1'b0; prev_r[d] = 1'b0;
        end
        tick;
        tick;
        chk("rst_gnt", 32'(gnt_a[0]), 32'd0);
        chk("rst_busy", 32'(busy_a[0]), 32'd0);
        chk("rst_q_shadow", 32'(q_a[0]), 32'd0);
        chk("rst_latch_en", 32'(en_a[0]), 32'd0);
        rst = 1'b0;
        tick;

        // Single set from requester 2
        req_a[0] = 4'b0100; set_a[0] = 4'b0100;
        sb.push_back(2);
        run(0, 1'b0);
        chk("set_gnt", 32'(r_g1), 32'h4);
        chk("set_s_first", 32'(r_s_first), 32'd1);
        chk("set_en_first", 32'(r_en_first), 32'd2);
        chk("set_en_cycles", 32'(r_en_cnt), 32'd1);
        chk("set_sr_cycles", 32'(r_s_cnt), 32'd3);
        chk("set_ack_latency", 32'(r_lat), 32'd4);
        chk("set_q_shadow", 32'(q_a[0]), 32'd1);
        req_a[0] = '0; set_a[0] = '0;

        // Illegal command from requester 1
        req_a[0] = 4'b0010; set_a[0] = 4'b0010; clr_a[0] = 4'b0010;
        sb.push_back(16 + 1);
        run(0, 1'b0);
        chk("ill_err_latency", 32'(r_lat), 32'd1);
        chk("ill_gnt", 32'(r_g1), 32'h2);
        chk("ill_en_cycles", 32'(r_en_cnt), 32'd0);
        chk("ill_sr_cycles", 32'(r_s_cnt), 32'd0);
        chk("ill_q_shadow", 32'(q_a[0]), 32'd1);
        req_a[0] = '0; set_a[0] = '0; clr_a[0] = '0;

        // Reset in the middle of STROBE
        req_a[0] = 4'b1000; clr_a[0] = 4'b1000;
        tick;
        tick;
        tick;
        chk("pre_rst_latch_en", 32'(en_a[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_latch_en", 32'(en_a[0]), 32'd0);
        chk("midrst_q_shadow", 32'(q_a[0]), 32'd0);
        chk("midrst_gnt", 32'(gnt_a[0]), 32'd0);
        chk("midrst_busy", 32'(busy_a[0]), 32'd0);
        req_a[0] = '0; clr_a[0] = '0;
        tick;
        rst = 1'b0;
        seen = '0;
        repeat (8) begin
            tick;
            seen = seen | ack_a[0];
        end
        chk("midrst_no_ack", 32'(seen), 32'd0);

        // Round robin with every requester clearing
        req_a[0] = 4'b1111; clr_a[0] = 4'b1111;
        sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
        for (int t = 0; t < 5; t++) begin
            run(0, 1'b0);
            chk("rr_ack_latency", 32'(r_lat), 32'd4);
            chk("rr_busy_at_ack", 32'(r_bdone), 32'd1);
            chk("rr_gap_idle", 32'(r_b0), 32'd0);
            chk("rr_gap_busy_after", 32'(r_b1), 32'd1);
        end
        req_a[0] = '0; clr_a[0] = '0;

        // Command churn after grant: the captured set must execute
        chk("churn_q_before", 32'(q_a[0]), 32'd0);
        req_a[0] = 4'b0001; set_a[0] = 4'b0001;
        sb.push_back(0);
        run(0, 1'b1);
        chk("churn_ack_latency", 32'(r_lat), 32'd4);
        chk("churn_q_shadow", 32'(q_a[0]), 32'd1);
        req_a[0] = '0; set_a[0] = '0; clr_a[0] = '0;

        // STROBE_CYC = 3 instance
        req_a[1] = 4'b0001; set_a[1] = 4'b0001;
        sb.push_back(0);
        run(1, 1'b0);
        chk("s3_ack_latency", 32'(r_lat), 32'd6);
        chk("s3_en_cycles", 32'(r_en_cnt), 32'd3);
        chk("s3_en_first", 32'(r_en_first), 32'd2);
        chk("s3_s_first", 32'(r_s_first), 32'd1);
        chk("s3_sr_cycles", 32'(r_s_cnt), 32'd5);
        chk("s3_q_shadow", 32'(q_a[1]), 32'd1);
        req_a[1] = '0; set_a[1] = '0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
